// File: rtl/serial_subtractor_8bit_pkg.sv
// Shared widths and FSM state encoding for the bit-serial 8-bit subtractor.
package serial_subtractor_8bit_pkg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_8bit_full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, with borrow-out.
module FullSubtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial 8-bit subtractor (LSB first, one bit per cycle, 9-cycle latency).
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor_8bit
   import serial_subtractor_8bit_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Binit,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             busy,
   output logic             done
`ifdef SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   state_t             state;
   state_t             state_next;
   logic               load;
   logic               shift;
   logic               last;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-1:0]   res_sr;
   logic               bor;
   logic [CNT_W-1:0]   cnt;
   logic               d_bit;
   logic               bout_bit;

   FullSubtractor u_fs (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (bor),
      .d    (d_bit),
      .bout (bout_bit)
   );

   // State register; busy/done are registered decodes of the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next == RUN);
         done  <= (state_next == DONE);
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      shift      = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            shift = 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Serial datapath: operands shift right, difference bits enter at the MSB
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         bor    <= 1'b0;
         cnt    <= '0;
         Diff   <= '0;
         Bout   <= 1'b0;
`ifdef SUB_OVF_EN
         ovf    <= 1'b0;
`endif
      end else if (load) begin
         a_sr   <= A;
         b_sr   <= B;
         res_sr <= '0;
         bor    <= Binit;
         cnt    <= '0;
      end else if (shift) begin
         a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
         res_sr <= {d_bit, res_sr[WIDTH-1:1]};
         bor    <= bout_bit;
         cnt    <= cnt + CNT_W'(1);
         if (last) begin
            Diff <= {d_bit, res_sr[WIDTH-1:1]};
            Bout <= bout_bit;
`ifdef SUB_OVF_EN
            // On the last bit a_sr[0]/b_sr[0] are the operand sign bits
            ovf  <= (a_sr[0] != b_sr[0]) && (d_bit != a_sr[0]);
`endif
         end
      end
   end

endmodule

// File: doc/serial_subtractor_8bit.md
SERIAL_SUBTRACTOR_8BIT -- requirements
Module: serial_subtractor_8bit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 A  input  8  minuend; sampled with start.
REQ-006 B  input  8  subtrahend; sampled with start.
REQ-007 Binit  input  1  borrow-in; sampled with start.
REQ-008 Diff  output  8  result A - B - Binit (mod 256); registered.
REQ-009 Bout  output  1  borrow-out of bit 7; registered.
REQ-010 busy  output  1  high while in RUN.
REQ-011 done  output  1  one-cycle pulse when Diff and Bout are valid.
REQ-012 ovf  output  1  signed (two's-complement) overflow; present only under SUB_OVF_EN.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN on start=1.
- RUN->DONE after the 8th bit.
- DONE->IDLE unconditionally after one cycle.
REQ-014 On start in IDLE (edge T), the block SHALL latch A and B into shift registers, load Binit into the borrow flop, clear the bit counter, and enter RUN.
REQ-015 In RUN, one bit per cycle, LSB first:
- d = a^b^bor
- bor_next = (~a&b) | (~(a^b)&bor)
- d is shifted into the MSB of the result register.
REQ-016 The bit counter SHALL be 3 bits; RUN SHALL end when the counter wraps from 7 to 0, i.e. exactly 8 RUN cycles, edges T+1..T+8.
REQ-017 Diff and Bout SHALL update at edge T+8; done=1 for the single cycle after T+8 (DONE state).
REQ-018 Diff and Bout SHALL hold their values until the next operation's edge T+8.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-020 start SHALL be ignored in RUN and DONE, with no effect on operands or result.
REQ-021 A, B and Binit changes after edge T SHALL NOT affect the result in progress.
REQ-022 Bout=1 SHALL indicate unsigned A < B + Binit.
REQ-023 Start-to-done latency SHALL be 9 cycles; throughput SHALL be one operation per 10 cycles (start held high continuously).

Reset
REQ-024 rst=1 SHALL immediately force: state IDLE, Diff=0x00, Bout=0, busy=0, done=0, ovf=0, counter=0, borrow flop=0, shift registers=0.
REQ-025 Reset mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL begin a fresh operation.

Configuration
REQ-026 Macro SUB_OVF_EN SHALL control the signed-overflow feature.
- Defined: port ovf exists, updates at T+8 and equals (A[7]!=B[7]) && (Diff[7]!=A[7]).
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Structure
REQ-027 A shared package SHALL hold:
- WIDTH=8
- CNT_W=3
- the FSM state typedef (IDLE, RUN, DONE).
REQ-028 The per-bit logic SHALL be a one-bit combinational sub-module FullSubtractor (a, b, bin -> d, bout), instantiated once and reused serially.

Verification
REQ-029 A=0x05, B=0x03, Binit=0, start -> done at T+9; Diff=0x02, Bout=0, busy high for 8 cycles.
REQ-030 A=0x00, B=0x01, Binit=0 -> Diff=0xFF, Bout=1; with SUB_OVF_EN, ovf=0.
REQ-031 A=0x80, B=0x01, Binit=0 -> Diff=0x7F, Bout=0; with SUB_OVF_EN, ovf=1.
REQ-032 A=0x10, B=0x0F, Binit=1 -> Diff=0x00, Bout=0; start re-pulsed with A=0xFF at T+3 -> ignored, result unchanged.
REQ-033 rst pulsed at T+4 of an operation -> all outputs 0 immediately, no done pulse; a new start with A=0x0A, B=0x0A -> Diff=0x00, Bout=0 at +9.
